// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file issue sequencer.
// Instruction layout: [8:6] opcode, [5:4] rd, [3:2] rs2, [1:0] rs1.
package regfile_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        WB     = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int unsigned INSTR_WIDTH    = 9;
    localparam int unsigned RF_FIELD_WIDTH = 6;
    localparam int unsigned OP_MSB  = 8;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_MSB  = 5;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 2;
    localparam int unsigned RS1_MSB = 1;
    localparam int unsigned RS1_LSB = 0;

    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]   op;
        logic [RD_MSB-RD_LSB:0]   rd;
        logic [RS2_MSB-RS2_LSB:0] rs2;
        logic [RS1_MSB-RS1_LSB:0] rs1;
    } instr_t;

    function automatic logic is_halt(input instr_t instr);
        return instr.op == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO with full/empty flags and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Issue controller: buffers instructions, starts the ALU one at a time, waits for
// completion (with timeout) and pulses the register-file write enable.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    input  logic [INSTR_WIDTH-1:0]    instr_in,
    output logic                      instr_ready,
    output logic [2:0]                alu_op,
    output logic                      alu_start,
    input  logic                      alu_done,
    output logic [RF_FIELD_WIDTH-1:0] rf_instruction,
    output logic                      rf_we,
    output logic                      busy,
    output logic                      halted,
    input  logic                      resume,
    output logic                      timeout_err,
    output logic [CNT_WIDTH-1:0]      retired_count
);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]    WAIT_ONE  = 1;
    localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = 1;

    state_e                        state;
    instr_t                        instr_q;
    logic [WAIT_W-1:0]             wait_cnt;
    instr_t                        fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    assign instr_ready = !fifo_full;
    assign fifo_pop    = (state == IDLE) && !fifo_empty;
    assign busy        = (state != IDLE) || (fifo_count != '0);

    // instr_q only changes on issue, so these stay constant from EXEC through WB.
    assign alu_op         = instr_q.op;
    assign rf_instruction = {instr_q.rd, instr_q.rs2, instr_q.rs1};

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (instr_valid && instr_ready),
        .wdata (instr_in),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            instr_q       <= '0;
            wait_cnt      <= '0;
            alu_start     <= 1'b0;
            rf_we         <= 1'b0;
            halted        <= 1'b0;
            timeout_err   <= 1'b0;
            retired_count <= '0;
        end else begin
            alu_start <= 1'b0;
            rf_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        instr_q  <= fifo_head;
                        wait_cnt <= '0;
                        if (is_halt(fifo_head)) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            state     <= EXEC;
                            alu_start <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    wait_cnt <= wait_cnt + WAIT_ONE;
                    if (alu_done) begin
                        state <= WB;
                        rf_we <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Abandon the instruction: no write-back, not retired.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WB: begin
                    retired_count <= retired_count + CNT_ONE;
                    state         <= IDLE;
                end
                HALTED: begin
                    if (resume) begin
                        halted <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer; a second instance with a 4-bit retire counter
// shares all stimulus to exercise counter wrap.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [8:0]  instr_in;
    logic        alu_done;
    logic        resume;
    logic        instr_ready, alu_start, rf_we, busy, halted, timeout_err;
    logic [2:0]  alu_op;
    logic [5:0]  rf_instruction;
    logic [15:0] retired_count;
    logic        instr_ready4, alu_start4, rf_we4, busy4, halted4, timeout_err4;
    logic [2:0]  alu_op4;
    logic [5:0]  rf_instruction4;
    logic [3:0]  retired_count4;

    int tests   = 0;
    int failed  = 0;
    int n_start = 0;
    int n_we    = 0;
    logic [8:0] we_log [$];
    logic [8:0] ins [6];

    always #5 clk = ~clk;

    regfile_sequencer u_dut (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_in       (instr_in),
        .instr_ready    (instr_ready),
        .alu_op         (alu_op),
        .alu_start      (alu_start),
        .alu_done       (alu_done),
        .rf_instruction (rf_instruction),
        .rf_we          (rf_we),
        .busy           (busy),
        .halted         (halted),
        .resume         (resume),
        .timeout_err    (timeout_err),
        .retired_count  (retired_count)
    );

    regfile_sequencer #(
        .CNT_WIDTH (4)
    ) u_dut4 (
        .clk            (clk),
        .rst            (rst),
        .instr_valid    (instr_valid),
        .instr_in       (instr_in),
        .instr_ready    (instr_ready4),
        .alu_op         (alu_op4),
        .alu_start      (alu_start4),
        .alu_done       (alu_done),
        .rf_instruction (rf_instruction4),
        .rf_we          (rf_we4),
        .busy           (busy4),
        .halted         (halted4),
        .resume         (resume),
        .timeout_err    (timeout_err4),
        .retired_count  (retired_count4)
    );

    // Pulse monitor: counts starts/writes and records {alu_op, rf_instruction} per write.
    always @(negedge clk) begin
        if (alu_start) n_start <= n_start + 1;
        if (rf_we) begin
            n_we <= n_we + 1;
            we_log.push_back({alu_op, rf_instruction});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] log_at(input int idx);
        if (idx < we_log.size()) return we_log[idx];
        return 9'bx;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_one(input logic [8:0] instr);
        instr_valid = 1'b1;
        instr_in    = instr;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        int   s0, s1, w0, k;
        logic rdy;

        ins[0] = 9'b001_00_01_10;
        ins[1] = 9'b010_01_10_11;
        ins[2] = 9'b011_10_11_00;
        ins[3] = 9'b100_11_00_01;
        ins[4] = 9'b101_00_10_01;
        ins[5] = 9'b110_11_01_10;

        rst = 1'b1; instr_valid = 1'b0; instr_in = '0; alu_done = 1'b0; resume = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_ready", instr_ready, 1);
        check("rst_start", alu_start, 0);
        check("rst_we", rf_we, 0);
        check("rst_rf", rf_instruction, 0);
        check("rst_op", alu_op, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_retired", retired_count, 0);

        // Single instruction, done on the first EXEC cycle
        s0 = n_start; w0 = n_we;
        push_one(9'b000_01_10_11);
        check("t1_busy_queued", busy, 1);
        check("t1_no_start_yet", alu_start, 0);
        alu_done = 1'b1;
        step();
        check("t1_start", alu_start, 1);
        check("t1_rf_exec", rf_instruction, 6'b011011);
        step();
        alu_done = 1'b0;
        check("t1_we", rf_we, 1);
        check("t1_start_drop", alu_start, 0);
        check("t1_rf_wb", rf_instruction, 6'b011011);
        step();
        check("t1_we_drop", rf_we, 0);
        check("t1_retired", retired_count, 1);
        check("t1_idle", busy, 0);
        step();
        check("t1_start_count", n_start - s0, 1);
        check("t1_we_count", n_we - w0, 1);

        // Fill the FIFO while the first instruction stalls in EXEC
        do_reset();
        w0 = n_we; k = 0;
        instr_valid = 1'b1; instr_in = ins[0];
        for (int c = 0; c < 7; c++) begin
            rdy = instr_ready && instr_valid;
            step();
            if (rdy) begin
                k++;
                if (k == 6) instr_valid = 1'b0; else instr_in = ins[k];
            end
        end
        check("t2_accepted", k, 5);
        check("t2_ready_low", instr_ready, 0);
        check("t2_busy", busy, 1);
        check("t2_no_we", n_we - w0, 0);
        alu_done = 1'b1;
        for (int c = 0; c < 60 && (n_we - w0) < 6; c++) begin
            rdy = instr_ready && instr_valid;
            step();
            if (rdy) begin
                k++;
                if (k == 6) instr_valid = 1'b0; else instr_in = ins[k];
            end
        end
        alu_done = 1'b0;
        check("t2_pushed", k, 6);
        check("t2_we_count", n_we - w0, 6);
        check("t2_retired", retired_count, 6);
        for (int n = 0; n < 6; n++) begin
            check("t2_order", log_at(w0 + n), ins[n]);
        end

        // HALT between two ADDs
        do_reset();
        s0 = n_start; w0 = n_we;
        alu_done = 1'b1;
        instr_valid = 1'b1;
        instr_in = 9'b000_01_00_10;
        step();
        instr_in = 9'b111_00_00_00;
        step();
        instr_in = 9'b000_10_01_11;
        step();
        instr_valid = 1'b0;
        for (int c = 0; c < 10 && !halted; c++) step();
        check("t3_halted", halted, 1);
        check("t3_one_start", n_start - s0, 1);
        check("t3_retired_a", retired_count, 1);
        check("t3_first_add", log_at(w0), 9'b000_01_00_10);
        step();
        step();
        check("t3_still_halted", halted, 1);
        check("t3_no_start_halted", n_start - s0, 1);
        check("t3_busy_halted", busy, 1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("t3_resumed", halted, 0);
        for (int c = 0; c < 10 && retired_count != 2; c++) step();
        check("t3_retired_b", retired_count, 2);
        check("t3_second_add", log_at(w0 + 1), 9'b000_10_01_11);
        alu_done = 1'b0;

        // ALU never completes
        do_reset();
        w0 = n_we;
        push_one(9'b001_11_10_01);
        step();
        check("t4_start", alu_start, 1);
        repeat (14) step();
        check("t4_no_err_yet", timeout_err, 0);
        check("t4_busy_exec", busy, 1);
        step();
        check("t4_err", timeout_err, 1);
        check("t4_idle", busy, 0);
        check("t4_no_we", n_we - w0, 0);
        alu_done = 1'b1;
        push_one(9'b010_00_11_10);
        for (int c = 0; c < 10 && retired_count != 1; c++) step();
        check("t4_next_retired", retired_count, 1);
        check("t4_next_written", log_at(w0), 9'b010_00_11_10);
        check("t4_err_sticky", timeout_err, 1);
        alu_done = 1'b0;

        // Reset during the second EXEC cycle
        do_reset();
        w0 = n_we;
        instr_valid = 1'b1;
        instr_in = 9'b011_10_01_11;
        step();
        instr_in = 9'b100_01_10_01;
        step();
        instr_valid = 1'b0;
        step();
        check("t5_rf_exec", rf_instruction, 6'b100111);
        rst = 1'b1;
        alu_done = 1'b1;
        step();
        rst = 1'b0;
        check("t5_we", rf_we, 0);
        check("t5_start", alu_start, 0);
        check("t5_rf", rf_instruction, 0);
        check("t5_op", alu_op, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", instr_ready, 1);
        check("t5_retired", retired_count, 0);
        s1 = n_start;
        repeat (4) step();
        check("t5_never_we", n_we - w0, 0);
        check("t5_fifo_flushed", n_start - s1, 0);
        alu_done = 1'b0;

        // 17 retirements: 16-bit counter reads 17, 4-bit counter wraps to 1
        do_reset();
        w0 = n_we; k = 0;
        alu_done = 1'b1;
        instr_valid = 1'b1; instr_in = 9'd0;
        for (int c = 0; c < 150 && (n_we - w0) < 17; c++) begin
            rdy = instr_ready && instr_valid;
            step();
            if (rdy) begin
                k++;
                if (k == 17) instr_valid = 1'b0; else instr_in = {3'b000, 6'(k)};
            end
        end
        step();
        alu_done = 1'b0;
        check("t6_we_count", n_we - w0, 17);
        check("t6_retired16", retired_count, 17);
        check("t6_retired4_wrap", retired_count4, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
